// File: rtl/pixel_fetch.sv
// pixel_fetch: streams packed pixel indices from the framebuffer RAM and
// unpacks them LSB-first into one BPP-bit palette select per active cycle.
// A one-word prefetch buffer hides the RAM's one-cycle read latency.
// Optional feature macro: UNDERRUN_DETECT_EN (builds the sticky underrun flag;
// when undefined, underrun_o is tied low).

package pixel_fetch_pkg;
  localparam int unsigned MODE_640X480X1BPPX60HZ = 0;
  localparam int unsigned MODE_640X480X3BPPX60HZ = 1;
  localparam int unsigned MODE_320X240X4BPPX60HZ = 2;
  localparam int unsigned MODE_320X240X8BPPX60HZ = 3;

  function automatic int unsigned GET_BPP(input int unsigned mode);
    case (mode)
      MODE_640X480X1BPPX60HZ: return 1;
      MODE_640X480X3BPPX60HZ: return 3;
      MODE_320X240X4BPPX60HZ: return 4;
      MODE_320X240X8BPPX60HZ: return 8;
      default:                return 3;
    endcase
  endfunction
endpackage

module pixel_fetch #(
  parameter  int unsigned MODE       = pixel_fetch_pkg::MODE_640X480X3BPPX60HZ,
  parameter  int unsigned WORD_WIDTH = 16,
  parameter  int unsigned ADDR_WIDTH = 16,
  parameter  int unsigned FB_WORDS   = 61440,
  localparam int unsigned BPP        = pixel_fetch_pkg::GET_BPP(MODE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic                  active_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [WORD_WIDTH-1:0] rd_data_i,
  output logic [BPP-1:0]        pixel_o,
  output logic                  pixel_valid_o,
  output logic                  underrun_o
);

  localparam int unsigned PPW = WORD_WIDTH / BPP;
  localparam int unsigned CW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CW-1:0]         LAST_PIX = CW'(PPW - 1);
  localparam logic [ADDR_WIDTH:0]   FB_END   = (ADDR_WIDTH + 1)'(FB_WORDS);

  if (PPW < 2) begin : g_bad_ppw
    $error("pixel_fetch: WORD_WIDTH must hold at least two pixels");
  end

  if (FB_WORDS == 0 || (ADDR_WIDTH < 32 && FB_WORDS > (32'd1 << ADDR_WIDTH))) begin : g_bad_fb
    $error("pixel_fetch: FB_WORDS does not fit the address space");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME0,
    ST_PRIME1,
    ST_STREAM
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic                  sh_valid_q, sh_valid_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] nb_q, nb_d;
  logic                  nb_valid_q, nb_valid_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [BPP-1:0]        pixel_q, pixel_d;
  logic                  pixel_valid_q, pixel_valid_d;

  logic                  rd_en;
  logic                  take_src;
  logic                  src_avail;
  logic [WORD_WIDTH-1:0] src_word;
  logic                  can_read;

  // Next-state, unpacking and read-issue logic.
  // The shift register is treated as empty on entering STREAM; an empty shift
  // register is refilled from the next-word buffer (or straight from the RAM
  // data bus when that word is arriving this cycle), and may hand out pixel 0
  // of that word in the same cycle. Each refill frees the buffer and issues
  // the next read.
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    sh_valid_d    = sh_valid_q;
    cnt_d         = cnt_q;
    nb_d          = nb_q;
    nb_valid_d    = nb_valid_q;
    addr_d        = addr_q;
    pixel_d       = '0;
    pixel_valid_d = 1'b0;
    rd_en         = 1'b0;
    take_src      = 1'b0;
    src_avail     = nb_valid_q | pend_q;
    src_word      = nb_valid_q ? nb_q : rd_data_i;
    can_read      = (addr_q < FB_END);

    if (frame_start_i) begin
      state_d    = ST_PRIME0;
      sh_valid_d = 1'b0;
      nb_valid_d = 1'b0;
      cnt_d      = '0;
      addr_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_PRIME0: begin
          rd_en   = can_read;
          state_d = ST_PRIME1;
        end
        ST_PRIME1: begin
          nb_d       = rd_data_i;
          nb_valid_d = 1'b1;
          state_d    = ST_STREAM;
        end
        ST_STREAM: begin
          if (pend_q) begin
            nb_d       = rd_data_i;
            nb_valid_d = 1'b1;
          end
          if (sh_valid_q && active_i) begin
            pixel_d       = sh_q[BPP-1:0];
            pixel_valid_d = 1'b1;
            if (cnt_q == LAST_PIX) begin
              take_src   = src_avail;
              sh_d       = src_word;
              sh_valid_d = src_avail;
              cnt_d      = '0;
            end else begin
              sh_d  = sh_q >> BPP;
              cnt_d = cnt_q + 1'b1;
            end
          end else if (!sh_valid_q && src_avail) begin
            take_src   = 1'b1;
            sh_valid_d = 1'b1;
            if (active_i) begin
              pixel_d       = src_word[BPP-1:0];
              pixel_valid_d = 1'b1;
              sh_d          = src_word >> BPP;
              cnt_d         = CW'(1);
            end else begin
              sh_d  = src_word;
              cnt_d = '0;
            end
          end
          if (take_src) begin
            nb_valid_d = 1'b0;
            rd_en      = can_read;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (rd_en) addr_d = addr_q + 1'b1;
    pend_d = rd_en;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      sh_q          <= '0;
      sh_valid_q    <= 1'b0;
      cnt_q         <= '0;
      nb_q          <= '0;
      nb_valid_q    <= 1'b0;
      pend_q        <= 1'b0;
      addr_q        <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      sh_valid_q    <= sh_valid_d;
      cnt_q         <= cnt_d;
      nb_q          <= nb_d;
      nb_valid_q    <= nb_valid_d;
      pend_q        <= pend_d;
      addr_q        <= addr_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign rd_en_o       = rd_en & ~rst_i;
  assign rd_addr_o     = addr_q[ADDR_WIDTH-1:0];
  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pixel_valid_q;

`ifdef UNDERRUN_DETECT_EN
  logic underrun_q, underrun_d;

  // Sticky underrun: any active cycle that yields no pixel sets it; a frame
  // start clears it, but an active cycle coinciding with that frame start
  // sets it again.
  always_comb begin
    underrun_d = frame_start_i ? 1'b0 : underrun_q;
    if (active_i && !pixel_valid_d) underrun_d = 1'b1;
  end

  // Underrun flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end

  assign underrun_o = underrun_q;
`else
  assign underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: fixed vector table, hand-written corner sequences and
// randomized traffic checked against a linear pixel-stream reference model.
module tb_pixel_fetch;
  localparam int unsigned WW   = 16;
  localparam int unsigned AW   = 16;
  localparam int unsigned NW   = 40;
  localparam int unsigned BPP  = 3;
  localparam int unsigned PPW  = WW / BPP;
  localparam int unsigned NPIX = NW * PPW;
  localparam int unsigned LINE = 13;
`ifdef UNDERRUN_DETECT_EN
  localparam bit UND_EN = 1'b1;
`else
  localparam bit UND_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          frame_start_i = 1'b0;
  logic          active_i = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [WW-1:0] rd_data_i = '0;
  logic [BPP-1:0] pixel_o;
  logic          pixel_valid_o;
  logic          underrun_o;

  pixel_fetch #(
    .MODE      (pixel_fetch_pkg::MODE_640X480X3BPPX60HZ),
    .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW),
    .FB_WORDS  (NW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .frame_start_i(frame_start_i),
    .active_i     (active_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .pixel_o      (pixel_o),
    .pixel_valid_o(pixel_valid_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] ram [NW];

  always @(posedge clk)
    if (rd_en_o === 1'b1 && rd_addr_o < AW'(NW)) rd_data_i <= ram[rd_addr_o];

  int total = 0;
  int bad = 0;

  // reference model state
  bit          m_framed;
  int unsigned m_age, m_idx, m_next_addr, m_reads, n_valid;
  logic [2:0]  e_pix;
  logic        e_val, e_und;

  // values sampled in the most recent cycle
  logic [2:0]  s_pix;
  logic        s_val, s_und, s_rd_en;
  logic [15:0] s_rd_addr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_pix(input int unsigned p);
    logic [WW-1:0] w;
    w = ram[p / PPW];
    w = w >> ((p % PPW) * BPP);
    return w[2:0];
  endfunction

  task automatic randomize_ram();
    for (int unsigned i = 0; i < NW; i++) ram[i] = WW'($urandom);
  endtask

  task automatic do_reset(input bit fs, input bit act);
    rst_i = 1'b1; frame_start_i = fs; active_i = act;
    @(posedge clk); #1;
    rst_i = 1'b0; frame_start_i = 1'b0; active_i = 1'b0;
    m_framed = 1'b0; m_idx = 0; m_next_addr = 0; m_reads = 0;
    e_pix = '0; e_val = 1'b0; e_und = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit fs, input bit act);
    bit accept;
    logic und_n;
    frame_start_i = fs; active_i = act;
    @(negedge clk);
    s_pix = pixel_o; s_val = pixel_valid_o; s_und = underrun_o;
    s_rd_en = rd_en_o; s_rd_addr = rd_addr_o;
    chk("pixel", pixel_o, e_pix);
    chk("valid", pixel_valid_o, e_val);
    chk("underrun", underrun_o, e_und);
    if (pixel_valid_o === 1'b1) n_valid++;
    if (rd_en_o !== 1'b0) begin
      chk("rd_addr_order", rd_addr_o, m_next_addr);
      chk("rd_allowed", (m_framed && m_next_addr < NW), 1);
      m_next_addr++; m_reads++;
    end
    if (fs) begin
      accept = 1'b0; m_framed = 1'b1; m_age = 0; m_idx = 0;
      m_next_addr = 0; m_reads = 0;
      und_n = act;
    end else begin
      if (m_age < 1000) m_age++;
      accept = act && m_framed && m_age >= 3 && m_idx < NPIX;
      und_n = e_und | (act && !accept);
    end
    e_val = accept;
    e_pix = accept ? ref_pix(m_idx) : 3'd0;
    if (accept) m_idx++;
    e_und = UND_EN ? und_n : 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          fs;
    bit          act;
    bit          val;
    logic [2:0]  pix;
    bit          rd;
    logic [15:0] addr;
  } vec_t;

  initial begin
    vec_t tv[11];
    int unsigned burst;

    tv[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd1};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 16'd0};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 16'd0};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 16'd0};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 16'd2};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 16'd0};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 16'd0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};

    randomize_ram();

    // reset values, then a quiet idle period
    do_reset(1'b1, 1'b1);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_pixel", pixel_o, 0);
    chk("rst_valid", pixel_valid_o, 0);
    chk("rst_underrun", underrun_o, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

    // known two-word pattern through the vector table
    ram[0] = 16'h7FAC;
    ram[1] = 16'h0001;
    for (int i = 0; i < 11; i++) begin
      cycle(tv[i].fs, tv[i].act);
      chk("tv_valid", s_val, tv[i].val);
      chk("tv_pixel", s_pix, tv[i].pix);
      chk("tv_rd_en", s_rd_en, tv[i].rd);
      if (tv[i].rd) chk("tv_rd_addr", s_rd_addr, tv[i].addr);
    end

    // whole frame in line-sized bursts (line width not a multiple of PPW)
    randomize_ram();
    cycle(1'b1, 1'b0);
    n_valid = 0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    for (int ln = 0; ln < 40 && m_idx < NPIX; ln++) begin
      for (int j = 0; j < int'(LINE) && m_idx < NPIX; j++) cycle(1'b0, 1'b1);
      for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0);
    end
    chk("frame_pixels", n_valid, NPIX);
    chk("frame_reads", m_reads, NW);
    chk("frame_underrun", underrun_o, 0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("exhausted_valid", s_val, 0);
    chk("exhausted_underrun", s_und, UND_EN);

    // active one cycle after frame start
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("early_valid", s_val, 0);
    chk("early_underrun", s_und, UND_EN);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    chk("early_underrun_held", s_und, UND_EN);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("underrun_cleared", s_und, 0);

    // frame restart in the middle of the stream
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 37; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("restart_rd_en", s_rd_en, 1);
    chk("restart_rd_addr", s_rd_addr, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("restart_rd1_en", s_rd_en, 1);
    chk("restart_rd1_addr", s_rd_addr, 1);
    cycle(1'b0, 1'b0);
    chk("restart_first_valid", s_val, 1);
    chk("restart_first_pixel", s_pix, ref_pix(0));

    // reset while streaming
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
    do_reset(1'b0, 1'b1);
    chk("rst_stream_valid", pixel_valid_o, 0);
    chk("rst_stream_pixel", pixel_o, 0);
    chk("rst_stream_rd_en", rd_en_o, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

    // randomized traffic against the model
    for (int seg = 0; seg < 20; seg++) begin
      if ($urandom_range(3) == 0) do_reset(1'($urandom), 1'($urandom));
      randomize_ram();
      cycle(1'b1, 1'($urandom));
      burst = $urandom_range(120, 260);
      for (int unsigned k = 0; k < burst; k++)
        cycle($urandom_range(199) == 0, $urandom_range(3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
